// File: rtl/game_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// game_pkg : shared state codes and display constants for the game controller
// Revision : 1.0
// ---------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_COUNTDOWN    = 3'd1,
        ST_PLAYING      = 3'd2,
        ST_PAUSED       = 3'd3,
        ST_INTERMISSION = 3'd4,
        ST_GAME_OVER    = 3'd5
    } state_t;

    localparam int         c_state_w = 3;
    localparam int         c_diff_w  = 2;
    localparam int         c_time_w  = 7;
    localparam int         c_round_w = 4;
    localparam logic [7:0] c_bcd_sat = 8'h99;

endpackage
`default_nettype wire

// File: rtl/bin2bcd_sat99.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bin2bcd_sat99 : binary to 2-digit BCD, values above 99 show as 99
// Revision      : 1.0
// ---------------------------------------------------------------------------
module bin2bcd_sat99
    import game_pkg::*;
#(
    parameter int IN_W = 8
) (
    input  logic [IN_W-1:0] i_bin,
    output logic [7:0]      o_bcd
);

    localparam logic [IN_W+7:0] c_max_bin = (IN_W + 8)'(99);

    logic [IN_W+7:0] w_ext;
    logic [6:0]      w_sat;

    always_comb begin
        w_ext = {8'd0, i_bin};
        w_sat = (w_ext > c_max_bin) ? 7'd99 : w_ext[6:0];
        o_bcd = (w_ext > c_max_bin) ? c_bcd_sat
                                    : {4'(w_sat / 7'd10), 4'(w_sat % 7'd10)};
    end

endmodule
`default_nettype wire

// File: rtl/game_round_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// game_round_ctrl : multi-round game sequencer with pause, timers, high score
// Revision        : 1.0
// ---------------------------------------------------------------------------
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int COUNTDOWN_SEC    = 5,
    parameter int ROUND_SEC        = 30,
    parameter int INTERMISSION_SEC = 3,
    parameter int NUM_ROUNDS       = 3,
    parameter int NUM_DIFF         = 3,
    parameter int SCORE_W          = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_1hz,
    input  logic               btn_start,
    input  logic               btn_pause,
    input  logic               btn_clear_score,
    input  logic               btn_difficulty,
    input  logic [1:0]         difficulty_in,
    input  logic [SCORE_W-1:0] score,
    output logic               enable_score,
    output logic               clear_score,
    output logic               enable_mole_ctrl,
    output logic [1:0]         difficulty_level,
    output logic [2:0]         state_o,
    output logic [3:0]         round_num,
    output logic [6:0]         time_left,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_high_score,
    output logic               game_over_pulse,
    output logic [7:0]         display_left,
    output logic [7:0]         display_right
);

    localparam logic [c_time_w-1:0]  c_cd_time    = c_time_w'(COUNTDOWN_SEC);
    localparam logic [c_time_w-1:0]  c_round_time = c_time_w'(ROUND_SEC);
    localparam logic [c_time_w-1:0]  c_inter_time = c_time_w'(INTERMISSION_SEC);
    localparam logic [c_time_w-1:0]  c_time_one   = c_time_w'(1);
    localparam logic [c_round_w-1:0] c_last_round = c_round_w'(NUM_ROUNDS);
    localparam logic [c_round_w-1:0] c_round_one  = c_round_w'(1);
    localparam logic [c_diff_w-1:0]  c_diff_max   = c_diff_w'(NUM_DIFF - 1);

    state_t               r_state, w_state_nxt;
    logic [c_time_w-1:0]  r_time, w_time_nxt;
    logic [c_round_w-1:0] r_round, w_round_nxt;
    logic [c_diff_w-1:0]  r_diff, w_diff_nxt, w_diff_req;
    logic [SCORE_W-1:0]   r_high, w_high_nxt;
    logic                 r_new_high, w_new_high_nxt;
    logic                 r_go, w_go_nxt;
    logic                 r_clear, w_clear_nxt;
    logic [7:0]           r_disp_l, r_disp_r, w_bcd_l, w_bcd_r;
    logic [c_time_w-1:0]  w_left_bin;
    logic [SCORE_W-1:0]   w_right_bin;

    assign w_diff_req = (int'(difficulty_in) >= NUM_DIFF) ? c_diff_max : difficulty_in;

    always_comb begin
        w_state_nxt    = r_state;
        w_time_nxt     = r_time;
        w_round_nxt    = r_round;
        w_diff_nxt     = r_diff;
        w_high_nxt     = r_high;
        w_new_high_nxt = r_new_high;
        w_go_nxt       = 1'b0;
        w_clear_nxt    = 1'b0;

        if (btn_start) begin
            w_state_nxt    = ST_COUNTDOWN;
            w_time_nxt     = c_cd_time;
            w_round_nxt    = c_round_one;
            w_clear_nxt    = 1'b1;
            w_new_high_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_GAME_OVER: begin
                    if (btn_clear_score) begin
                        w_clear_nxt    = 1'b1;
                        w_high_nxt     = '0;
                        w_new_high_nxt = 1'b0;
                    end
                    if (btn_difficulty) w_diff_nxt = w_diff_req;
                end
                ST_COUNTDOWN: begin
                    if (tick_1hz) begin
                        if (r_time == c_time_one) begin
                            w_state_nxt = ST_PLAYING;
                            w_time_nxt  = c_round_time;
                        end else begin
                            w_time_nxt = r_time - c_time_one;
                        end
                    end
                end
                ST_PLAYING: begin
                    if (btn_clear_score) w_clear_nxt = 1'b1;
                    if (btn_pause) begin
                        w_state_nxt = ST_PAUSED;
                    end else if (tick_1hz) begin
                        if (r_time != c_time_one) begin
                            w_time_nxt = r_time - c_time_one;
                        end else if (r_round < c_last_round) begin
                            w_state_nxt = ST_INTERMISSION;
                            w_time_nxt  = c_inter_time;
                        end else begin
                            w_state_nxt = ST_GAME_OVER;
                            w_time_nxt  = '0;
                            w_go_nxt    = 1'b1;
                            if (score > r_high) begin
                                w_high_nxt     = score;
                                w_new_high_nxt = 1'b1;
                            end
                        end
                    end
                end
                ST_PAUSED: begin
                    if (btn_clear_score) w_clear_nxt = 1'b1;
                    if (btn_pause) w_state_nxt = ST_PLAYING;
                end
                ST_INTERMISSION: begin
                    if (tick_1hz) begin
                        if (r_time == c_time_one) begin
                            w_state_nxt = ST_PLAYING;
                            w_time_nxt  = c_round_time;
                            w_round_nxt = r_round + c_round_one;
                        end else begin
                            w_time_nxt = r_time - c_time_one;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Displays are built from next-state values so they change on the same edge as the state.
    always_comb begin
        w_left_bin  = w_time_nxt;
        w_right_bin = score;
        case (w_state_nxt)
            ST_IDLE, ST_GAME_OVER: w_left_bin = '0;
            ST_INTERMISSION:       w_left_bin = c_time_w'(w_round_nxt);
            default:               w_left_bin = w_time_nxt;
        endcase
        if (w_state_nxt == ST_IDLE) w_right_bin = SCORE_W'(w_diff_nxt);
    end

    bin2bcd_sat99 #(.IN_W(c_time_w)) u_bcd_left (
        .i_bin (w_left_bin),
        .o_bcd (w_bcd_l)
    );

    bin2bcd_sat99 #(.IN_W(SCORE_W)) u_bcd_right (
        .i_bin (w_right_bin),
        .o_bcd (w_bcd_r)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_time     <= '0;
            r_round    <= '0;
            r_diff     <= '0;
            r_high     <= '0;
            r_new_high <= 1'b0;
            r_go       <= 1'b0;
            r_clear    <= 1'b1;
            r_disp_l   <= '0;
            r_disp_r   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_time     <= w_time_nxt;
            r_round    <= w_round_nxt;
            r_diff     <= w_diff_nxt;
            r_high     <= w_high_nxt;
            r_new_high <= w_new_high_nxt;
            r_go       <= w_go_nxt;
            r_clear    <= w_clear_nxt;
            r_disp_l   <= w_bcd_l;
            r_disp_r   <= w_bcd_r;
        end
    end

    assign enable_score     = (r_state == ST_PLAYING);
    assign enable_mole_ctrl = (r_state == ST_PLAYING);
    assign clear_score      = r_clear;
    assign difficulty_level = r_diff;
    assign state_o          = r_state;
    assign round_num        = r_round;
    assign time_left        = r_time;
    assign high_score       = r_high;
    assign new_high_score   = r_new_high;
    assign game_over_pulse  = r_go;
    assign display_left     = r_disp_l;
    assign display_right    = r_disp_r;

endmodule
`default_nettype wire

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
Parametrised, multi-round game controller for the whack-a-mole design. It owns its own countdown, round and intermission timers, driven by a 1 Hz tick. It adds pause/resume, a configurable number of rounds per game and high-score tracking. It drives the score and mole-control enables and produces BCD values for the 4-digit display.

Parameters:
COUNTDOWN_SEC, 5, pre-game countdown length in seconds (1..9)
ROUND_SEC, 30, length of each playing round in seconds (1..99)
INTERMISSION_SEC, 3, gap between rounds in seconds (1..9)
NUM_ROUNDS, 3, rounds per game (1..9)
NUM_DIFF, 3, number of difficulty levels (1..4)
SCORE_W, 8, score width

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
tick_1hz  in  1  one-cycle pulse once per second
btn_start  in  1  one-cycle pulse; start or restart the game
btn_pause  in  1  one-cycle pulse; toggle pause
btn_clear_score  in  1  one-cycle pulse
btn_difficulty  in  1  one-cycle pulse; latch difficulty_in
difficulty_in  in  2  requested difficulty
score  in  SCORE_W  running score from the score block (binary)
enable_score  out  1  score counting allowed
clear_score  out  1  one-cycle clear to the score block
enable_mole_ctrl  out  1  mole generator run
difficulty_level  out  2  latched difficulty
state_o  out  3  current state code
round_num  out  4  current round, 1..NUM_ROUNDS (0 in IDLE)
time_left  out  7  seconds remaining in the current timed state (binary)
high_score  out  SCORE_W  best final score since reset or clear
new_high_score  out  1  last game set a new high score
game_over_pulse  out  1  one-cycle pulse on entry to GAME_OVER
display_left  out  8  BCD: time_left, or round number in INTERMISSION
display_right  out  8  BCD: score saturated at 99, or difficulty in IDLE

Behaviour:
- Reset (rst_n low at clk edge):
  - State IDLE; all enables 0; clear_score 1.
  - time_left 0; round_num 0; difficulty_level 0.
  - high_score 0; new_high_score 0; game_over_pulse 0; displays 8'h00.
- Output timing: all outputs are registered or decoded from registered state. A response appears on the clk edge after the triggering input; there is no combinational input-to-output path.
- States and codes: IDLE=0, COUNTDOWN=1, PLAYING=2, PAUSED=3, INTERMISSION=4, GAME_OVER=5.
- Timer rule: entering a timed state loads time_left with that state's length. Each tick_1hz decrements it. A tick while time_left==1 performs the exit transition instead of decrementing, loading the next state's value.
- Transitions:
  - IDLE/GAME_OVER + btn_start -> COUNTDOWN: round_num=1, clear_score pulse, new_high_score cleared.
  - COUNTDOWN expiry -> PLAYING.
  - PLAYING expiry -> INTERMISSION if round_num<NUM_ROUNDS, else GAME_OVER.
  - INTERMISSION expiry -> PLAYING with round_num+1.
  - PLAYING + btn_pause -> PAUSED; time_left frozen, ticks ignored.
  - PAUSED + btn_pause -> PLAYING, resuming with the same time_left.
  - btn_start in any non-IDLE state -> COUNTDOWN (full restart, same actions as from IDLE).
- Input priority in the same cycle: btn_start > btn_pause > tick_1hz expiry.
- btn_pause is ignored outside PLAYING/PAUSED.
- Enables:
  - enable_score and enable_mole_ctrl are 1 only in PLAYING; both are 0 in PAUSED.
  - Score is not cleared between rounds; it accumulates over the game.
- GAME_OVER entry:
  - game_over_pulse=1 for one cycle.
  - If score > high_score (strict), high_score<=score and new_high_score<=1.
- btn_clear_score:
  - In IDLE/GAME_OVER: clear_score pulse, high_score<=0, new_high_score<=0.
  - In PLAYING/PAUSED: clear_score pulse only.
  - Ignored in COUNTDOWN/INTERMISSION.
- Difficulty:
  - btn_difficulty is accepted only in IDLE/GAME_OVER; ignored elsewhere.
  - Values >= NUM_DIFF are clamped to NUM_DIFF-1.
- Display:
  - display_right shows BCD score, saturating at 8'h99; in IDLE it shows the BCD difficulty.
  - display_left shows BCD time_left; in INTERMISSION it shows BCD round_num; in IDLE/GAME_OVER it shows 8'h00.

Decomposition:
- Package game_pkg: state enum and codes, BCD saturate constant 8'h99, difficulty width.
- Shared with game_control_fsm users.
- One sub-module: bin2bcd_sat99, combinational binary-to-2-digit BCD with saturation. It is instantiated for both display paths.

Test Plan:
All scenarios use COUNTDOWN_SEC=3, ROUND_SEC=4, INTERMISSION_SEC=2, NUM_ROUNDS=2.
1. Reset, then btn_start -> next cycle state_o=1, time_left=3, round_num=1, clear_score=1 for one cycle. After 3 ticks -> state_o=2, time_left=4, enable_mole_ctrl=1.
2. Full game with score held at 8'd42 -> 4 ticks: INTERMISSION with display_left=8'h01; 2 ticks: PLAYING, round_num=2; 4 ticks: GAME_OVER with game_over_pulse for one cycle, high_score=42, new_high_score=1.
3. In PLAYING at time_left=3, btn_pause, then 5 ticks -> time_left stays 3 and enables are 0. btn_pause again -> PLAYING, and the next tick gives time_left=2.
4. In PLAYING, btn_start, btn_pause and a final expiry tick all in the same cycle -> COUNTDOWN, time_left=3, round_num=1.
5. Second game with final score 8'd30 after high_score=42 -> high_score stays 42, new_high_score=0. btn_clear_score in GAME_OVER -> high_score=0.
6. btn_difficulty with difficulty_in=3 in IDLE -> difficulty_level=2 and display_right=8'h02. The same press during PLAYING -> no change. score=8'd150 in PLAYING -> display_right=8'h99.
